// File: rtl/bp_me_dma_resp_pkg.sv
// Shared types and helpers for the cache DMA responder.
//   bp_me_dma_resp_state_e : responder FSM states
//   blk_off_bits()         : byte-offset bits covered by one cache block
package bp_me_dma_resp_pkg;

  typedef enum logic [2:0] {
    e_init,
    e_ready,
    e_read_wait,
    e_read,
    e_write
  } bp_me_dma_resp_state_e;

  // log2 of the block size in bytes
  function automatic int unsigned blk_off_bits(input int unsigned beats,
                                               input int unsigned width);
    return $clog2(beats * width / 8);
  endfunction

endpackage

// File: rtl/bp_me_dma_resp_mem.sv
// Beat storage: one synchronous write port, one asynchronous read port.
// Contents are never reset.
//   clk_i            clock
//   w_v_i/w_addr_i/w_data_i   write port
//   r_addr_i/r_data_o         combinational read port
module bp_me_dma_resp_mem #(
  parameter int unsigned els_p   = 4096,
  parameter int unsigned width_p = 64
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [$clog2(els_p)-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [$clog2(els_p)-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_me_cache_dma_responder.sv
// Memory-side responder for the bsg_cache DMA interface. Read packets return
// a block of fill beats after read_latency_p idle cycles; write packets
// absorb a block of evict beats into internal storage. One packet in flight.
// Optional macro BP_ME_DMA_RESP_ZERO_INIT_EN: after reset, sweep storage to
// zero (one beat per cycle) before accepting packets.
// Ports:
//   clk_i, reset_n_i                      clock, async active-low reset
//   dma_pkt_i/_v_i/_yumi_o                {write_not_read, addr} packet
//   dma_data_o/_v_o/_ready_and_i          read fill beats to the cache
//   dma_data_i/_v_i/_yumi_o               write evict beats from the cache
module bp_me_cache_dma_responder
  import bp_me_dma_resp_pkg::*;
#(
  parameter int unsigned caddr_width_p    = 28,
  parameter int unsigned dma_data_width_p = 64,
  parameter int unsigned block_beats_p    = 8,
  parameter int unsigned mem_els_p        = 4096,
  parameter int unsigned read_latency_p   = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [caddr_width_p:0]      dma_pkt_i,
  input  logic                        dma_pkt_v_i,
  output logic                        dma_pkt_yumi_o,
  output logic [dma_data_width_p-1:0] dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_ready_and_i,
  input  logic [dma_data_width_p-1:0] dma_data_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_yumi_o
);

  localparam int unsigned beat_w = $clog2(block_beats_p);
  localparam int unsigned idx_w  = $clog2(mem_els_p);
  localparam int unsigned set_w  = idx_w - beat_w;
  localparam int unsigned off_w  = blk_off_bits(block_beats_p, dma_data_width_p);
  localparam int unsigned lat_w  = (read_latency_p > 1) ? $clog2(read_latency_p) : 1;

  typedef struct packed {
    logic                     write_not_read;
    logic [caddr_width_p-1:0] addr;
  } dma_pkt_s;

`ifdef BP_ME_DMA_RESP_ZERO_INIT_EN
  localparam bp_me_dma_resp_state_e reset_state = e_init;
`else
  localparam bp_me_dma_resp_state_e reset_state = e_ready;
`endif

  dma_pkt_s pkt;
  assign pkt = dma_pkt_i;

  // Only the in-range block bits are kept; the rest wrap away silently.
  logic unused_addr_bits;
  assign unused_addr_bits = ^pkt.addr;

  bp_me_dma_resp_state_e state_q, state_n;
  logic [set_w-1:0]  blk_q, blk_n;
  logic [beat_w-1:0] beat_q, beat_n;
  logic [lat_w-1:0]  lat_q, lat_n;
  logic [idx_w-1:0]  idx;
  logic              last_beat;

  logic                        pkt_yumi, data_v, data_yumi;
  logic                        mem_w_v;
  logic [idx_w-1:0]            mem_w_addr;
  logic [dma_data_width_p-1:0] mem_w_data;

  // Beat index = block number * block_beats_p + beat, modulo storage depth
  assign idx       = {blk_q, beat_q};
  assign last_beat = (beat_q == beat_w'(block_beats_p - 1));

`ifdef BP_ME_DMA_RESP_ZERO_INIT_EN
  logic [idx_w-1:0] init_q, init_n;
`endif

  // State and counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= reset_state;
      blk_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
`ifdef BP_ME_DMA_RESP_ZERO_INIT_EN
      init_q  <= '0;
`endif
    end else begin
      state_q <= state_n;
      blk_q   <= blk_n;
      beat_q  <= beat_n;
      lat_q   <= lat_n;
`ifdef BP_ME_DMA_RESP_ZERO_INIT_EN
      init_q  <= init_n;
`endif
    end
  end

  // Next state, handshakes and storage write mux
  always_comb begin
    state_n    = state_q;
    blk_n      = blk_q;
    beat_n     = beat_q;
    lat_n      = lat_q;
    pkt_yumi   = 1'b0;
    data_v     = 1'b0;
    data_yumi  = 1'b0;
    mem_w_v    = 1'b0;
    mem_w_addr = idx;
    mem_w_data = dma_data_i;
`ifdef BP_ME_DMA_RESP_ZERO_INIT_EN
    init_n     = init_q;
`endif
    unique case (state_q)
`ifdef BP_ME_DMA_RESP_ZERO_INIT_EN
      e_init: begin
        mem_w_v    = 1'b1;
        mem_w_addr = init_q;
        mem_w_data = '0;
        init_n     = init_q + idx_w'(1);
        if (init_q == idx_w'(mem_els_p - 1)) state_n = e_ready;
      end
`endif
      e_ready: begin
        pkt_yumi = dma_pkt_v_i;
        if (dma_pkt_v_i) begin
          blk_n  = pkt.addr[off_w +: set_w];
          beat_n = '0;
          if (pkt.write_not_read) begin
            state_n = e_write;
          end else if (read_latency_p > 0) begin
            state_n = e_read_wait;
            lat_n   = lat_w'(read_latency_p - 1);
          end else begin
            state_n = e_read;
          end
        end
      end
      e_read_wait: begin
        if (lat_q == '0) state_n = e_read;
        else             lat_n   = lat_q - lat_w'(1);
      end
      e_read: begin
        data_v = 1'b1;
        if (dma_data_ready_and_i) begin
          beat_n = beat_q + beat_w'(1);
          if (last_beat) state_n = e_ready;
        end
      end
      e_write: begin
        data_yumi = dma_data_v_i;
        if (dma_data_v_i) begin
          mem_w_v = 1'b1;
          beat_n  = beat_q + beat_w'(1);
          if (last_beat) state_n = e_ready;
        end
      end
      default: state_n = e_ready;
    endcase
  end

  bp_me_dma_resp_mem #(
    .els_p  (mem_els_p),
    .width_p(dma_data_width_p)
  ) mem (
    .clk_i   (clk_i),
    .w_v_i   (mem_w_v),
    .w_addr_i(mem_w_addr),
    .w_data_i(mem_w_data),
    .r_addr_i(idx),
    .r_data_o(dma_data_o)
  );

  assign dma_pkt_yumi_o  = pkt_yumi;
  assign dma_data_v_o    = data_v;
  assign dma_data_yumi_o = data_yumi;

endmodule

// File: tb/tb_bp_me_cache_dma_responder.sv
// Directed bench for bp_me_cache_dma_responder (default parameters,
// read_latency_p = 4, 64-byte blocks, 4096-beat storage).
module tb_bp_me_cache_dma_responder;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [28:0] dma_pkt_i;
  logic        dma_pkt_v_i;
  logic        dma_pkt_yumi_o;
  logic [63:0] dma_data_o;
  logic        dma_data_v_o;
  logic        dma_data_ready_and_i;
  logic [63:0] dma_data_i;
  logic        dma_data_v_i;
  logic        dma_data_yumi_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  bp_me_cache_dma_responder dut (
    .clk_i               (clk_i),
    .reset_n_i           (reset_n_i),
    .dma_pkt_i           (dma_pkt_i),
    .dma_pkt_v_i         (dma_pkt_v_i),
    .dma_pkt_yumi_o      (dma_pkt_yumi_o),
    .dma_data_o          (dma_data_o),
    .dma_data_v_o        (dma_data_v_o),
    .dma_data_ready_and_i(dma_data_ready_and_i),
    .dma_data_i          (dma_data_i),
    .dma_data_v_i        (dma_data_v_i),
    .dma_data_yumi_o     (dma_data_yumi_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write one block of beats base..base+7 with a one-cycle bubble after beat 3
  task automatic do_write(input logic [27:0] a, input logic [63:0] base);
    @(negedge clk_i);
    dma_pkt_i   = {1'b1, a};
    dma_pkt_v_i = 1'b1;
    #1 check("wr_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd1);
    @(negedge clk_i);
    dma_pkt_v_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        dma_data_v_i = 1'b0;
        #1 check("wr_bubble_yumi", 64'(dma_data_yumi_o), 64'd0);
        @(negedge clk_i);
      end
      dma_data_v_i = 1'b1;
      dma_data_i   = base + 64'(i);
      #1 check("wr_beat_yumi", 64'(dma_data_yumi_o), 64'd1);
      @(negedge clk_i);
    end
    // Block complete: a further evict beat must be left pending
    dma_data_i = 64'hdead;
    #1 check("wr_stray_yumi", 64'(dma_data_yumi_o), 64'd0);
    dma_data_v_i = 1'b0;
  endtask

  // Read one block; first beat due 5 cycles after yumi. bp selects the
  // 1,0,0,1 ready pattern; abort_at>0 pulses reset after that many beats.
  task automatic do_read(input logic [27:0] a, input logic [63:0] base,
                         input bit bp, input int abort_at);
    int cyc, beats, nv;
    bit r;
    @(negedge clk_i);
    dma_pkt_i            = {1'b0, a};
    dma_pkt_v_i          = 1'b1;
    dma_data_ready_and_i = 1'b0;
    #1 check("rd_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd1);
    @(negedge clk_i);
    dma_pkt_v_i = 1'b0;
    cyc = 1; beats = 0; nv = 0;
    while (beats < 8 && cyc < 64) begin
      if (abort_at > 0 && beats == abort_at) begin
        reset_n_i = 1'b0;
        #1 check("abort_v", 64'(dma_data_v_o), 64'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        dma_data_ready_and_i = 1'b0;
        return;
      end
      #1;
      if (cyc == 2) begin
        dma_pkt_v_i = 1'b1;
        check("busy_no_yumi", 64'(dma_pkt_yumi_o), 64'd0);
        dma_pkt_v_i = 1'b0;
      end
      if (cyc < 5) begin
        check("lat_gap_v", 64'(dma_data_v_o), 64'd0);
      end else begin
        check("beat_v", 64'(dma_data_v_o), 64'd1);
        check("beat_data", dma_data_o, base + 64'(beats));
        r  = bp ? (nv % 4 == 0 || nv % 4 == 3) : 1'b1;
        nv++;
        dma_data_ready_and_i = r;
        if (r) beats++;
      end
      @(negedge clk_i);
      cyc++;
    end
    check("beat_count", 64'(beats), 64'd8);
    dma_data_ready_and_i = 1'b0;
    #1 check("post_v", 64'(dma_data_v_o), 64'd0);
  endtask

  initial begin
    reset_n_i            = 1'b0;
    dma_pkt_i            = '0;
    dma_pkt_v_i          = 1'b0;
    dma_data_ready_and_i = 1'b1;
    dma_data_i           = 64'h55;
    dma_data_v_i         = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_data_v", 64'(dma_data_v_o), 64'd0);
    check("rst_data_yumi", 64'(dma_data_yumi_o), 64'd0);
    check("rst_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
    @(negedge clk_i);
    reset_n_i            = 1'b1;
    dma_data_v_i         = 1'b0;
    dma_data_ready_and_i = 1'b0;

    do_write(28'h40, 64'h1000);
    do_read(28'h40, 64'h1000, 1'b0, 0);
    // Backpressure; the following write also confirms yumi returns
    do_read(28'h40, 64'h1000, 1'b1, 0);
    do_write(28'h80, 64'h2000);
    // 0x40 + 4096 beats * 8 bytes aliases onto the same storage
    do_read(28'h40 + 28'h8000, 64'h1000, 1'b0, 0);
    do_read(28'h80, 64'h2000, 1'b0, 0);
    // Abort mid-read after 3 beats, then a clean read elsewhere
    do_read(28'h80, 64'h2000, 1'b0, 3);
    @(negedge clk_i);
    #1 check("post_abort_v", 64'(dma_data_v_o), 64'd0);
    do_read(28'h40, 64'h1000, 1'b0, 0);
    do_read(28'h80, 64'h2000, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
